// File: rtl/dpram_pkg.sv
// Shared DPRAM geometry and timing constants, used by the FIFO controller,
// the DPRAM model and their benches.
package dpram_pkg;

    localparam int RAM_WIDTH = 8;
    localparam int RAM_DEPTH = 16;
    localparam int ADDR_SZ   = $clog2(RAM_DEPTH);
    localparam int DEL       = 1;

    typedef logic [RAM_WIDTH-1:0] word_t;
    typedef logic [ADDR_SZ-1:0]   addr_t;
    typedef logic [ADDR_SZ:0]     ptr_t;
    typedef logic [ADDR_SZ+1:0]   lvl_t;

endpackage

// File: rtl/dpram_fifo_obuf.sv
// Two-entry in-order output buffer that sits behind the DPRAM read port.
// The head entry is a register, so the popped data leaves straight from a flop.
module dpram_fifo_obuf
    import dpram_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  word_t      din_i,
    input  logic       pop_i,
    output word_t      head_o,
    output logic       valid_o,
    output logic [1:0] cnt_o
);

    word_t      ent0_q, ent0_d;
    word_t      ent1_q, ent1_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = din_i;
                else               ent1_d = din_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the arrival lands behind whatever remains.
                if (cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = din_i;
                end else begin
                    ent0_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 2'd0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

    assign head_o  = ent0_q;
    assign valid_o = (cnt_q != 2'd0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving an external DPRAM: pointers, flow control and
// one-cycle read-latency hiding through a two-entry output buffer.
module dpram_fifo_ctrl
    import dpram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RAM_WIDTH-1:0] wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ADDR_SZ+1:0]   level,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic [ADDR_SZ-1:0]   ram_wr_address,
    output logic                 ram_write,
    output logic [ADDR_SZ-1:0]   ram_rd_address,
    output logic                 ram_read,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic       inflight_q, inflight_d;
    ptr_t       mem_cnt;
    logic       full;
    logic       push;
    logic       pop;
    logic       issue;
    logic [1:0] obuf_cnt;
    logic [2:0] pend;

    assign mem_cnt  = wr_ptr_q - rd_ptr_q;
    assign full     = (mem_cnt == ptr_t'(RAM_DEPTH));
    assign wr_ready = !full && !reset;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    // Keep at most two words between the RAM and the consumer; a pop this
    // cycle frees a slot, which is what sustains one word per cycle.
    assign pend  = {1'b0, obuf_cnt} + {2'b00, inflight_q};
    assign issue = !reset && (mem_cnt != '0) && (pend < (3'd2 + {2'b00, pop}));

    assign ram_write      = push;
    assign ram_wr_address = wr_ptr_q[ADDR_SZ-1:0];
    assign ram_data_in    = wr_data;
    assign ram_read       = issue;
    assign ram_rd_address = rd_ptr_q[ADDR_SZ-1:0];

    assign wr_ptr_d   = wr_ptr_q + ptr_t'(push);
    assign rd_ptr_d   = rd_ptr_q + ptr_t'(issue);
    assign inflight_d = issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Reset has priority inside the buffer, so a read in flight is dropped.
    dpram_fifo_obuf u_obuf (
        .clk     (clk),
        .rst     (reset),
        .push_i  (inflight_q),
        .din_i   (ram_data_out),
        .pop_i   (pop),
        .head_o  (rd_data),
        .valid_o (rd_valid),
        .cnt_o   (obuf_cnt)
    );

    assign level = lvl_t'(mem_cnt) + lvl_t'(inflight_q) + lvl_t'(obuf_cnt);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural DPRAM and a pop-order scoreboard.
module tb_dpram_fifo_ctrl;
    import dpram_pkg::*;

    logic                 clk;
    logic                 reset;
    logic [RAM_WIDTH-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [RAM_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_SZ+1:0]   level;
    logic [RAM_WIDTH-1:0] ram_data_in;
    logic [ADDR_SZ-1:0]   ram_wr_address;
    logic                 ram_write;
    logic [ADDR_SZ-1:0]   ram_rd_address;
    logic                 ram_read;
    logic [RAM_WIDTH-1:0] ram_data_out;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] sb [$];
    int                   errors = 0;
    int                   checks = 0;
    int                   pops   = 0;
    logic                 hold_v = 1'b0;
    logic [RAM_WIDTH-1:0] hold_d = '0;

    dpram_fifo_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .level          (level),
        .ram_data_in    (ram_data_in),
        .ram_wr_address (ram_wr_address),
        .ram_write      (ram_write),
        .ram_rd_address (ram_rd_address),
        .ram_read       (ram_read),
        .ram_data_out   (ram_data_out)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= #DEL mem[ram_rd_address];
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (level != '0 && t < 60) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk_eq(tag, 32'(level), 32'd0);
    endtask

    // Handshake monitor: scoreboard push/pop, hold stability, address collision.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk_eq("hold", 32'(rd_data), 32'(hold_d));
            if (rd_valid && rd_ready) begin
                chk_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk_eq("pop_data", 32'(rd_data), 32'(sb.pop_front()));
                pops++;
            end
            if (wr_valid && wr_ready) sb.push_back(wr_data);
            if (ram_write && ram_read)
                chk_eq("addr_coll", 32'(ram_wr_address != ram_rd_address), 32'd1);
            hold_v = rd_valid && !rd_ready;
            hold_d = rd_data;
        end
    end

    initial begin
        #(200 * 20000);
        $display("FAIL timeout: bench did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int t;
        int p0;
        int first;
        logic [RAM_WIDTH-1:0] head;

        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk_eq("rst_level", 32'(level), 32'd0);
        chk_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk_eq("rst_ram_write", 32'(ram_write), 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        cyc();

        // Fill: 18 words FF..EE with the consumer stalled
        n = 0;
        t = 0;
        while (n < 18 && t < 60) begin
            wr_valid = 1'b1;
            wr_data  = 8'(255 - n);
            @(negedge clk);
            if (wr_ready) n++;
            t++;
            cyc();
        end
        wr_valid = 1'b0;
        chk_eq("fill_cnt", 32'(n), 32'd18);
        cyc();
        cyc();
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        @(negedge clk);
        chk_eq("full_wr_ready", 32'(wr_ready), 32'd0);
        chk_eq("full_level", 32'(level), 32'd18);
        chk_eq("full_rd_data", 32'(rd_data), 32'hFF);
        chk_eq("full_rd_valid", 32'(rd_valid), 32'd1);
        cyc();
        wr_valid = 1'b0;
        @(negedge clk);
        chk_eq("full_level_after_ignored_push", 32'(level), 32'd18);
        cyc();

        // Drain: one pop per cycle
        rd_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk_eq("drain_vld", 32'(rd_valid), 32'd1);
            cyc();
        end
        @(negedge clk);
        chk_eq("drain_pops", 32'(pops - p0), 32'd18);
        chk_eq("drain_rd_valid", 32'(rd_valid), 32'd0);
        chk_eq("drain_level", 32'(level), 32'd0);
        cyc();

        // Stream: latency 3, then steady level 3
        do_reset();
        rd_ready = 1'b1;
        first = -1;
        for (int k = 0; k < 20; k++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(k);
            @(negedge clk);
            if (rd_valid && first < 0) first = k;
            if (k >= 3) begin
                chk_eq("stream_level", 32'(level), 32'd3);
                chk_eq("stream_vld", 32'(rd_valid), 32'd1);
            end
            cyc();
        end
        wr_valid = 1'b0;
        chk_eq("stream_latency", 32'(first), 32'd3);
        wait_empty("stream_empty");
        cyc();

        // Wrap: 40 words, random backpressure, pointers from zero
        do_reset();
        n = 0;
        t = 0;
        p0 = pops;
        while ((pops - p0) < 40 && t < 800) begin
            wr_valid = (n < 40);
            wr_data  = 8'(n);
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (wr_valid && wr_ready) n++;
            t++;
            cyc();
        end
        wr_valid = 1'b0;
        chk_eq("wrap_pushes", 32'(n), 32'd40);
        chk_eq("wrap_pops", 32'(pops - p0), 32'd40);
        rd_ready = 1'b1;
        wait_empty("wrap_empty");
        cyc();

        // Reset mid-operation with a read in flight
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            cyc();
        end
        wr_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk_eq("pre_rst_level", 32'(level), 32'd6);
        cyc();
        rd_ready = 1'b1;
        @(negedge clk);
        cyc();
        reset    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        @(negedge clk);
        chk_eq("midrst_level_inflight", 32'(level), 32'd5);
        chk_eq("midrst_wr_ready", 32'(wr_ready), 32'd0);
        chk_eq("midrst_ram_write", 32'(ram_write), 32'd0);
        chk_eq("midrst_ram_read", 32'(ram_read), 32'd0);
        cyc();
        reset   = 1'b0;
        wr_data = 8'hA5;
        @(negedge clk);
        chk_eq("postrst_rd_valid", 32'(rd_valid), 32'd0);
        chk_eq("postrst_level", 32'(level), 32'd0);
        chk_eq("postrst_wr_ready", 32'(wr_ready), 32'd1);
        cyc();
        wr_valid = 1'b0;
        p0 = pops;
        t = 0;
        @(negedge clk);
        while (pops == p0 && t < 10) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk_eq("postrst_pops", 32'(pops - p0), 32'd1);
        cyc();

        // Backpressure: head held, reads stop with the buffer full
        rd_ready = 1'b0;
        n = 0;
        t = 0;
        while (t < 10) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + n);
            @(negedge clk);
            if (wr_ready) n++;
            t++;
            if (rd_valid) break;
            cyc();
        end
        chk_eq("bp_vld", 32'(rd_valid), 32'd1);
        chk_eq("bp_head", 32'(rd_data), 32'h40);
        head = rd_data;
        cyc();
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + n);
            @(negedge clk);
            if (wr_ready) n++;
            chk_eq("bp_hold", 32'(rd_data), 32'(head));
            chk_eq("bp_noread", 32'(ram_read), 32'd0);
            cyc();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk_eq("bp_level", 32'(level), 32'(n));
        cyc();
        rd_ready = 1'b1;
        wait_empty("bp_empty");
        cyc();
        chk_eq("sb_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
